// File: rtl/alu_pkg.sv
// Shared opcode, ALU control and state encodings for the ALU issue block.
// Imported by alu_op_decode and alu_issue.
package alu_pkg;

  localparam logic [3:0] OP_AND     = 4'd0;
  localparam logic [3:0] OP_OR      = 4'd1;
  localparam logic [3:0] OP_ADD     = 4'd2;
  localparam logic [3:0] OP_SUB     = 4'd3;
  localparam logic [3:0] OP_NOR     = 4'd4;
  localparam logic [3:0] OP_NAND    = 4'd5;
  localparam logic [3:0] OP_SLT     = 4'd6;
  localparam logic [3:0] OP_SGT     = 4'd7;
  localparam logic [3:0] OP_SLE     = 4'd8;
  localparam logic [3:0] OP_SGE     = 4'd9;
  localparam logic [3:0] OP_SEQ     = 4'd10;
  localparam logic [3:0] OP_SNE     = 4'd11;
  localparam logic [3:0] OP_ABSDIFF = 4'd12;

  // ctrl[3]=A_invert, ctrl[2]=B_invert/cin, ctrl[1:0]=operation
  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_SLT  = 4'b0111;
  localparam logic [3:0] CTRL_NOR  = 4'b1100;
  localparam logic [3:0] CTRL_NAND = 4'b1101;

  localparam logic [2:0] BONUS_SLT  = 3'b000;
  localparam logic [2:0] BONUS_SGT  = 3'b001;
  localparam logic [2:0] BONUS_SLE  = 3'b010;
  localparam logic [2:0] BONUS_SGE  = 3'b011;
  localparam logic [2:0] BONUS_SNE  = 3'b100;
  localparam logic [2:0] BONUS_SEQ  = 3'b110;
  localparam logic [2:0] BONUS_NONE = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC1,
    ST_EXEC2,
    ST_RESP
  } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: op_i -> ALU ctrl_o, bonus_o, illegal_o.
// Illegal opcodes decode to a harmless AND/NONE with illegal_o=1.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] op_i,
  output logic [3:0]     ctrl_o,
  output logic [2:0]     bonus_o,
  output logic           illegal_o
);

  always_comb begin
    ctrl_o    = CTRL_AND;
    bonus_o   = BONUS_NONE;
    illegal_o = 1'b0;
    unique case (op_i)
      OP_AND:     ctrl_o = CTRL_AND;
      OP_OR:      ctrl_o = CTRL_OR;
      OP_ADD:     ctrl_o = CTRL_ADD;
      OP_SUB:     ctrl_o = CTRL_SUB;
      OP_NOR:     ctrl_o = CTRL_NOR;
      OP_NAND:    ctrl_o = CTRL_NAND;
      OP_SLT: begin
        ctrl_o  = CTRL_SLT;
        bonus_o = BONUS_SLT;
      end
      OP_SGT: begin
        ctrl_o  = CTRL_SLT;
        bonus_o = BONUS_SGT;
      end
      OP_SLE: begin
        ctrl_o  = CTRL_SLT;
        bonus_o = BONUS_SLE;
      end
      OP_SGE: begin
        ctrl_o  = CTRL_SLT;
        bonus_o = BONUS_SGE;
      end
      OP_SEQ: begin
        ctrl_o  = CTRL_SLT;
        bonus_o = BONUS_SEQ;
      end
      OP_SNE: begin
        ctrl_o  = CTRL_SLT;
        bonus_o = BONUS_SNE;
      end
      OP_ABSDIFF: ctrl_o = CTRL_SUB;
      default:    illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// Issue/writeback front end for the ripple ALU: req handshake in,
// one or two ALU passes, registered result/flags out on rsp handshake.
module alu_issue
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OPW-1:0]   req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_src1,
  output logic [WIDTH-1:0] alu_src2,
  output logic [3:0]       alu_ctrl,
  output logic [2:0]       alu_bonus,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_cout,
  input  logic             alu_ovf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic             rsp_err
);

  state_e           state_q, state_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             zero_q, zero_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic [3:0]       dec_ctrl;
  logic [2:0]       dec_bonus;
  logic             dec_illegal;

  alu_op_decode #(
    .OPW(OPW)
  ) u_dec (
    .op_i      (op_q),
    .ctrl_o    (dec_ctrl),
    .bonus_o   (dec_bonus),
    .illegal_o (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      zero_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    data_d    = data_q;
    zero_d    = zero_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    alu_ctrl  = CTRL_AND;
    alu_bonus = BONUS_NONE;
    alu_src1  = a_q;
    alu_src2  = b_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          state_d = ST_EXEC1;
        end
      end
      ST_EXEC1: begin
        alu_ctrl  = dec_ctrl;
        alu_bonus = dec_bonus;
        state_d   = ST_RESP;
        if (dec_illegal) begin
          data_d = '0;
          zero_d = 1'b0;
          cout_d = 1'b0;
          ovf_d  = 1'b0;
          err_d  = 1'b1;
        end else begin
          data_d = alu_result;
          zero_d = alu_zero;
          cout_d = alu_cout;
          ovf_d  = alu_ovf;
          err_d  = 1'b0;
          // negative raw a-b: redo as b-a
          if (op_q == OP_ABSDIFF && alu_result[WIDTH-1])
            state_d = ST_EXEC2;
        end
      end
      ST_EXEC2: begin
        alu_ctrl = CTRL_SUB;
        alu_src1 = b_q;
        alu_src2 = a_q;
        data_d   = alu_result;
        zero_d   = alu_zero;
        cout_d   = alu_cout;
        ovf_d    = alu_ovf;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready)
          state_d = ST_IDLE;
      end
    endcase
  end

  // gated so ready stays low while reset is held
  assign req_ready = rst_n & (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = data_q;
  assign rsp_zero  = zero_q;
  assign rsp_cout  = cout_q;
  assign rsp_ovf   = ovf_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue with a behavioural ripple-ALU model.
// Vector table plus hand sequences for backpressure and mid-op reset.
module tb_alu_issue;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [3:0]  alu_ctrl;
  logic [2:0]  alu_bonus;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_cout;
  logic        alu_ovf;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_zero;
  logic        rsp_cout;
  logic        rsp_ovf;
  logic        rsp_err;

  alu_issue #(
    .WIDTH(32),
    .OPW(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .alu_ctrl   (alu_ctrl),
    .alu_bonus  (alu_bonus),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .alu_cout   (alu_cout),
    .alu_ovf    (alu_ovf),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_zero   (rsp_zero),
    .rsp_cout   (rsp_cout),
    .rsp_ovf    (rsp_ovf),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural ripple ALU
  logic [31:0] mx, my;
  logic [32:0] msum;
  logic        mless;
  always_comb begin
    mx    = alu_ctrl[3] ? ~alu_src1 : alu_src1;
    my    = alu_ctrl[2] ? ~alu_src2 : alu_src2;
    msum  = {1'b0, mx} + {1'b0, my} + {32'd0, alu_ctrl[2]};
    mless = 1'b0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    case (alu_ctrl[1:0])
      2'b00: alu_result = mx & my;
      2'b01: alu_result = mx | my;
      2'b10: begin
        alu_result = msum[31:0];
        alu_cout   = msum[32];
        alu_ovf    = (mx[31] == my[31]) && (msum[31] != mx[31]);
      end
      default: begin
        alu_cout = msum[32];
        alu_ovf  = (mx[31] == my[31]) && (msum[31] != mx[31]);
        case (alu_bonus)
          3'b001:  mless = $signed(alu_src1) > $signed(alu_src2);
          3'b010:  mless = $signed(alu_src1) <= $signed(alu_src2);
          3'b011:  mless = $signed(alu_src1) >= $signed(alu_src2);
          3'b110:  mless = alu_src1 == alu_src2;
          3'b100:  mless = alu_src1 != alu_src2;
          default: mless = $signed(alu_src1) < $signed(alu_src2);
        endcase
        alu_result = {31'd0, mless};
      end
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    logic        zero;
    logic        cout;
    logic        ovf;
    logic        err;
    logic        chk_flags;
    logic        chk_ctrl;
    logic [3:0]  ctrl;
    logic [2:0]  bonus;
    int          lat;
  } vec_t;

  int   checks;
  int   errors;
  vec_t tbl[19];
  vec_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
    input logic [31:0] d, input logic z, input logic c, input logic v,
    input logic e, input logic cf, input logic cc,
    input logic [3:0] ct, input logic [2:0] bo, input int lat);
    vec_t r;
    r.op = op; r.a = a; r.b = b; r.data = d; r.zero = z;
    r.cout = c; r.ovf = v; r.err = e; r.chk_flags = cf;
    r.chk_ctrl = cc; r.ctrl = ct; r.bonus = bo; r.lat = lat;
    return r;
  endfunction

  task automatic compare_rsp(input int lat, input logic [3:0] ct,
                             input logic [2:0] bo);
    vec_t e;
    e = sb.pop_front();
    chk("lat", lat, e.lat);
    chk("data", rsp_data, e.data);
    chk("zero", {31'd0, rsp_zero}, {31'd0, e.zero});
    chk("err", {31'd0, rsp_err}, {31'd0, e.err});
    if (e.chk_flags) begin
      chk("cout", {31'd0, rsp_cout}, {31'd0, e.cout});
      chk("ovf", {31'd0, rsp_ovf}, {31'd0, e.ovf});
    end
    if (e.chk_ctrl) begin
      chk("ctrl", {28'd0, ct}, {28'd0, e.ctrl});
      chk("bonus", {29'd0, bo}, {29'd0, e.bonus});
    end
  endtask

  // drive one request, wait for the response, check and consume it
  task automatic run(input vec_t v);
    int         lat;
    logic [3:0] ct;
    logic [2:0] bo;
    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = v.op;
    req_a     = v.a;
    req_b     = v.b;
    sb.push_back(v);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    ct  = 4'hf;
    bo  = 3'b000;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        ct = alu_ctrl;
        bo = alu_bonus;
      end
    end while (!rsp_valid && lat < 10);
    if (!rsp_valid) begin
      chk("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
      void'(sb.pop_front());
    end else begin
      compare_rsp(lat, ct, bo);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic chk_reset_vals;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_flags", {28'd0, rsp_zero, rsp_cout, rsp_ovf, rsp_err},
        32'd0);
    chk("rst_ctrl", {28'd0, alu_ctrl}, 32'd0);
    chk("rst_bonus", {29'd0, alu_bonus}, 32'd7);
    chk("rst_src1", alu_src1, 32'd0);
    chk("rst_src2", alu_src2, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    vec_t v;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 4'd0;
    req_a     = 32'd0;
    req_b     = 32'd0;
    rsp_ready = 1'b0;

    //            op     a             b             data
    tbl[0]  = mk(4'd0,  32'hF0F01234, 32'h0FF0FF00, 32'h00F01200,
                 0, 0, 0, 0, 0, 1, 4'b0000, 3'b111, 2);
    tbl[1]  = mk(4'd1,  32'hF0000000, 32'h0000000F, 32'hF000000F,
                 0, 0, 0, 0, 0, 1, 4'b0001, 3'b111, 2);
    tbl[2]  = mk(4'd2,  32'd7,        32'd5,        32'd12,
                 0, 0, 0, 0, 1, 1, 4'b0010, 3'b111, 2);
    tbl[3]  = mk(4'd2,  32'hFFFFFFFF, 32'd1,        32'd0,
                 1, 1, 0, 0, 1, 1, 4'b0010, 3'b111, 2);
    tbl[4]  = mk(4'd3,  32'h80000000, 32'd1,        32'h7FFFFFFF,
                 0, 1, 1, 0, 1, 1, 4'b0110, 3'b111, 2);
    tbl[5]  = mk(4'd4,  32'hFF00FF00, 32'h00FF0000, 32'h000000FF,
                 0, 0, 0, 0, 0, 1, 4'b1100, 3'b111, 2);
    tbl[6]  = mk(4'd5,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,
                 1, 0, 0, 0, 0, 1, 4'b1101, 3'b111, 2);
    tbl[7]  = mk(4'd6,  32'hFFFFFFFF, 32'd1,        32'd1,
                 0, 0, 0, 0, 0, 1, 4'b0111, 3'b000, 2);
    tbl[8]  = mk(4'd7,  32'd5,        32'hFFFFFFFD, 32'd1,
                 0, 0, 0, 0, 0, 1, 4'b0111, 3'b001, 2);
    tbl[9]  = mk(4'd8,  32'd4,        32'd4,        32'd1,
                 0, 0, 0, 0, 0, 1, 4'b0111, 3'b010, 2);
    tbl[10] = mk(4'd9,  32'd2,        32'd3,        32'd0,
                 1, 0, 0, 0, 0, 1, 4'b0111, 3'b011, 2);
    tbl[11] = mk(4'd10, 32'h1234,     32'h1234,     32'd1,
                 0, 0, 0, 0, 0, 1, 4'b0111, 3'b110, 2);
    tbl[12] = mk(4'd11, 32'h1234,     32'h1234,     32'd0,
                 1, 0, 0, 0, 0, 1, 4'b0111, 3'b100, 2);
    tbl[13] = mk(4'd12, 32'd10,       32'd3,        32'd7,
                 0, 1, 0, 0, 1, 1, 4'b0110, 3'b111, 2);
    tbl[14] = mk(4'd12, 32'd3,        32'd10,       32'd7,
                 0, 1, 0, 0, 1, 1, 4'b0110, 3'b111, 3);
    tbl[15] = mk(4'd14, 32'd9,        32'd9,        32'd0,
                 0, 0, 0, 1, 1, 0, 4'b0000, 3'b111, 2);
    tbl[16] = mk(4'd2,  32'd1,        32'd1,        32'd2,
                 0, 0, 0, 0, 1, 1, 4'b0010, 3'b111, 2);
    tbl[17] = mk(4'd15, 32'hFFFFFFFF, 32'd1,        32'd0,
                 0, 0, 0, 1, 1, 0, 4'b0000, 3'b111, 2);
    tbl[18] = mk(4'd12, 32'd5,        32'd5,        32'd0,
                 1, 1, 0, 0, 1, 1, 4'b0110, 3'b111, 2);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;
    #1 chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

    foreach (tbl[i]) run(tbl[i]);

    // backpressure: hold the response, a new request must wait
    v = mk(4'd2, 32'd2, 32'd3, 32'd5, 0, 0, 0, 0, 1, 0,
           4'b0010, 3'b111, 2);
    @(negedge clk);
    req_valid = 1'b1; req_op = v.op; req_a = v.a; req_b = v.b;
    sb.push_back(v);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    compare_rsp(2, 4'b0000, 3'b000);
    req_valid = 1'b1; req_op = 4'd1;
    req_a = 32'h10; req_b = 32'h01;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_hold_data", rsp_data, 32'd5);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_ready_back", {31'd0, req_ready}, 32'd1);
    chk("bp_valid_drop", {31'd0, rsp_valid}, 32'd0);
    sb.push_back(mk(4'd1, 32'h10, 32'h01, 32'h11, 0, 0, 0, 0, 0, 0,
                    4'b0001, 3'b111, 2));
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 10);
    compare_rsp(lat, 4'b0000, 3'b000);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;

    // reset during EXEC1 of a two-pass ABSDIFF
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'd12; req_a = 32'd3; req_b = 32'd10;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("exec1_ctrl", {28'd0, alu_ctrl}, 32'b0110);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;
    #1 chk("ready_after_rst2", {31'd0, req_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("no_rsp_after_rst", {31'd0, rsp_valid}, 32'd0);
    end
    run(mk(4'd3, 32'd0, 32'd0, 32'd0, 1, 1, 0, 0, 1, 1,
           4'b0110, 3'b111, 2));

    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
